// File: rtl/phys_reg_free_list.sv
// Free list of the 64 physical registers: two-wide lowest-index allocation plus writeback frees.
// Optional sticky double-free detection is built only when FREE_LIST_CHECK_EN is defined.
module phys_reg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int LOW_WATER = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  alloc_req,
  input  logic [63:0] free_regs,
  output logic        alloc_grant,
  output logic [5:0]  alloc_reg_1,
  output logic [5:0]  alloc_reg_2,
  output logic [6:0]  free_count,
  output logic        almost_empty,
  output logic        double_free_err
);

  localparam logic [63:0] RESET_MAP   = {64{1'b1}} << NUM_AREGS;
  localparam logic [6:0]  RESET_COUNT = 7'(NUM_PREGS - NUM_AREGS);

  logic [63:0] free_map_q, free_map_d;
  logic [6:0]  free_count_q, free_count_d;
  logic        almost_empty_q, almost_empty_d;

  logic [63:0] remaining;
  logic [63:0] released;
  logic [63:0] newly_free;
  logic [63:0] alloc_mask;
  logic [6:0]  alloc_num;
  logic [6:0]  newly_cnt;

  // Lookahead: lowest free register, then the lowest one above it.
  always_comb begin
    alloc_reg_1 = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (free_map_q[i]) alloc_reg_1 = 6'(i);
    end
    remaining   = free_map_q & ~(64'h1 << alloc_reg_1);
    alloc_reg_2 = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (remaining[i]) alloc_reg_2 = 6'(i);
    end
  end

  always_comb begin
    case (alloc_req)
      2'd1:    alloc_grant = (free_count_q >= 7'd1);
      2'd2:    alloc_grant = (free_count_q >= 7'd2);
      default: alloc_grant = 1'b0;
    endcase
  end

  // p0 stays pinned to x0, so bit 0 of the release mask is dropped before anything else.
  always_comb begin
    alloc_mask = 64'h0;
    alloc_num  = 7'd0;
    if (alloc_grant) begin
      alloc_mask = 64'h1 << alloc_reg_1;
      alloc_num  = 7'd1;
      if (alloc_req == 2'd2) begin
        alloc_mask = alloc_mask | (64'h1 << alloc_reg_2);
        alloc_num  = 7'd2;
      end
    end
    released   = free_regs & ~64'h1;
    newly_free = released & ~free_map_q;
    newly_cnt  = 7'd0;
    for (int i = 0; i < 64; i++) begin
      newly_cnt = newly_cnt + {6'd0, newly_free[i]};
    end
    free_map_d     = (free_map_q & ~alloc_mask) | released;
    free_count_d   = free_count_q - alloc_num + newly_cnt;
    almost_empty_d = (free_count_d <= 7'(LOW_WATER));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_map_q     <= RESET_MAP;
      free_count_q   <= RESET_COUNT;
      almost_empty_q <= 1'b0;
    end else begin
      free_map_q     <= free_map_d;
      free_count_q   <= free_count_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign free_count   = free_count_q;
  assign almost_empty = almost_empty_q;

`ifdef FREE_LIST_CHECK_EN
  logic double_free_err_q, double_free_err_d;

  always_comb begin
    double_free_err_d = double_free_err_q | (|(released & free_map_q));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) double_free_err_q <= 1'b0;
    else       double_free_err_q <= double_free_err_d;
  end

  assign double_free_err = double_free_err_q;
`else
  assign double_free_err = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list with a set-of-free-registers reference model.
// Compile with +define+FREE_LIST_CHECK_EN to also cover the double-free flag.
module tb_phys_reg_free_list;

  logic        clk;
  logic        reset;
  logic [1:0]  alloc_req;
  logic [63:0] free_regs;
  logic        alloc_grant;
  logic [5:0]  alloc_reg_1;
  logic [5:0]  alloc_reg_2;
  logic [6:0]  free_count;
  logic        almost_empty;
  logic        double_free_err;

  int n_checks = 0;
  int n_errors = 0;

  phys_reg_free_list dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_req      (alloc_req),
    .free_regs      (free_regs),
    .alloc_grant    (alloc_grant),
    .alloc_reg_1    (alloc_reg_1),
    .alloc_reg_2    (alloc_reg_2),
    .free_count     (free_count),
    .almost_empty   (almost_empty),
    .double_free_err(double_free_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain membership table of free registers.
  bit model_free[64];
  bit model_err;

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 64; i++) if (model_free[i]) c++;
    return c;
  endfunction

  function automatic int model_nth_free(input int n);
    int seen = 0;
    for (int i = 0; i < 64; i++) begin
      if (model_free[i]) begin
        if (seen == n) return i;
        seen++;
      end
    end
    return 0;
  endfunction

  function automatic bit model_grant(input logic [1:0] req);
    if (req == 2'd1) return model_count() >= 1;
    if (req == 2'd2) return model_count() >= 2;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) model_free[i] = (i >= 32);
      model_err = 1'b0;
    end else begin
      int  r1, r2;
      bit  g;
      g  = model_grant(alloc_req);
      r1 = model_nth_free(0);
      r2 = model_nth_free(1);
      for (int i = 1; i < 64; i++) if (free_regs[i] && model_free[i]) model_err = 1'b1;
      if (g) begin
        model_free[r1] = 1'b0;
        if (alloc_req == 2'd2) model_free[r2] = 1'b0;
      end
      for (int i = 1; i < 64; i++) if (free_regs[i]) model_free[i] = 1'b1;
    end
  end

  // Compare process: mid-cycle, inputs and state both settled.
  always @(negedge clk) begin
    if (!reset) begin
      int  cnt;
      bit  err_exp;
      cnt = model_count();
`ifdef FREE_LIST_CHECK_EN
      err_exp = model_err;
`else
      err_exp = 1'b0;
`endif
      checkOutput("cmp_grant", 64'(alloc_grant), 64'(model_grant(alloc_req)));
      checkOutput("cmp_reg1", 64'(alloc_reg_1), 64'(model_nth_free(0)));
      checkOutput("cmp_reg2", 64'(alloc_reg_2), 64'(model_nth_free(1)));
      checkOutput("cmp_count", 64'(free_count), 64'(cnt));
      checkOutput("cmp_almost_empty", 64'(almost_empty), 64'(cnt <= 4));
      checkOutput("cmp_err", 64'(double_free_err), 64'(err_exp));
    end
  end

  task automatic applyStimulus(input logic [1:0] req, input logic [63:0] fr);
    @(posedge clk);
    #2;
    alloc_req = req;
    free_regs = fr;
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    alloc_req = 2'd0;
    free_regs = 64'h0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    applyStimulus(2'd2, 64'h0);
    checkOutput("rst_count", 64'(free_count), 64'd32);
    checkOutput("rst_almost_empty", 64'(almost_empty), 64'd0);
    checkOutput("rst_err", 64'(double_free_err), 64'd0);
    checkOutput("first_grant", 64'(alloc_grant), 64'd1);
    checkOutput("first_reg1", 64'(alloc_reg_1), 64'd32);
    checkOutput("first_reg2", 64'(alloc_reg_2), 64'd33);

    applyStimulus(2'd0, 64'h0);
    checkOutput("after_first_count", 64'(free_count), 64'd30);
    checkOutput("after_first_reg1", 64'(alloc_reg_1), 64'd34);
    checkOutput("after_first_reg2", 64'(alloc_reg_2), 64'd35);

    for (int k = 1; k <= 15; k++) begin
      applyStimulus(2'd2, 64'h0);
      if (k == 13) checkOutput("ae_at_6", 64'(almost_empty), 64'd0);
      if (k == 14) begin
        checkOutput("count_at_4", 64'(free_count), 64'd4);
        checkOutput("ae_at_4", 64'(almost_empty), 64'd1);
      end
    end
    applyStimulus(2'd1, 64'h0);
    checkOutput("drained_count", 64'(free_count), 64'd0);
    checkOutput("drained_ae", 64'(almost_empty), 64'd1);
    checkOutput("drained_grant", 64'(alloc_grant), 64'd0);

    applyStimulus(2'd0, 64'h1 << 45);
    applyStimulus(2'd2, 64'h0);
    checkOutput("one_left_count", 64'(free_count), 64'd1);
    checkOutput("one_left_req2_grant", 64'(alloc_grant), 64'd0);
    applyStimulus(2'd1, 64'h0);
    checkOutput("one_left_count_held", 64'(free_count), 64'd1);
    checkOutput("one_left_req1_grant", 64'(alloc_grant), 64'd1);
    checkOutput("one_left_reg1", 64'(alloc_reg_1), 64'd45);

    applyStimulus(2'd2, (64'h1 << 40) | (64'h1 << 7));
    checkOutput("empty_count", 64'(free_count), 64'd0);
    checkOutput("empty_free_grant", 64'(alloc_grant), 64'd0);
    applyStimulus(2'd0, 64'h1);
    checkOutput("refill_count", 64'(free_count), 64'd2);
    checkOutput("refill_reg1", 64'(alloc_reg_1), 64'd7);
    checkOutput("refill_reg2", 64'(alloc_reg_2), 64'd40);

    applyStimulus(2'd0, 64'h1 << 50);
    checkOutput("p0_ignored_count", 64'(free_count), 64'd2);
    applyStimulus(2'd0, 64'h1 << 50);
    checkOutput("free50_count", 64'(free_count), 64'd3);
    applyStimulus(2'd0, 64'h0);
    checkOutput("double_free_count", 64'(free_count), 64'd3);
`ifdef FREE_LIST_CHECK_EN
    checkOutput("double_free_err", 64'(double_free_err), 64'd1);
`else
    checkOutput("double_free_err", 64'(double_free_err), 64'd0);
`endif
    applyStimulus(2'd0, 64'h0);
`ifdef FREE_LIST_CHECK_EN
    checkOutput("double_free_sticky", 64'(double_free_err), 64'd1);
`else
    checkOutput("double_free_sticky", 64'(double_free_err), 64'd0);
`endif

    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    for (int k = 0; k < 10; k++) applyStimulus(2'd1, 64'h0);
    applyStimulus(2'd1, 64'h1 << 3);
    checkOutput("mid_count", 64'(free_count), 64'd22);
    checkOutput("mid_reg1", 64'(alloc_reg_1), 64'd42);
    applyStimulus(2'd0, 64'h0);
    checkOutput("alloc_free_count", 64'(free_count), 64'd22);
    checkOutput("alloc_free_reg1", 64'(alloc_reg_1), 64'd3);
    checkOutput("alloc_free_reg2", 64'(alloc_reg_2), 64'd43);

    #1 reset = 1'b1;
    #1;
    checkOutput("async_rst_count", 64'(free_count), 64'd32);
    checkOutput("async_rst_reg1", 64'(alloc_reg_1), 64'd32);
    checkOutput("async_rst_reg2", 64'(alloc_reg_2), 64'd33);
    checkOutput("async_rst_ae", 64'(almost_empty), 64'd0);
    checkOutput("async_rst_err", 64'(double_free_err), 64'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    applyStimulus(2'd2, 64'h0);
    applyStimulus(2'd0, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
